// File: rtl/dtc_pkg.sv
// Shared DTC link constants and framer state encoding.
// Imported by the event framer, the lane serializer and the command decoder.
package dtc_pkg;

  localparam logic [15:0] EVENT_HEADER = 16'h5C5C;
  localparam logic [15:0] SYNC_WORD    = 16'hBC50;
  localparam logic [15:0] END_FLAG     = 16'hC5D5;
  localparam logic [3:0]  CH_HDR_TAG   = 4'hA;

  typedef logic [2:0] framer_state_t;

  localparam framer_state_t StIdle   = 3'd0;
  localparam framer_state_t StHdr    = 3'd1;
  localparam framer_state_t StEvCnt  = 3'd2;
  localparam framer_state_t StChHdr  = 3'd3;
  localparam framer_state_t StSample = 3'd4;
  localparam framer_state_t StCsum   = 3'd5;
  localparam framer_state_t StEnd0   = 3'd6;
  localparam framer_state_t StEnd1   = 3'd7;

endpackage

// File: rtl/dtc_word_serializer.sv
// Word-to-nibble lane serializer: free-running 4-slot phase, word load on slot 0,
// sync word inserted whenever the framer has nothing to send.
module dtc_word_serializer
  import dtc_pkg::*;
(
  input  logic        dtc_clk,
  input  logic        rst_n,
  input  logic [15:0] word,
  input  logic        word_valid,
  output logic        word_load,
  output logic [1:0]  phase,
  output logic [3:0]  dtc_out
);

  logic [1:0]  phase_q, phase_d;
  logic [15:0] shreg_q, shreg_d;
  logic [3:0]  out_q, out_d;

  always_comb begin
    phase_d   = phase_q + 2'd1;
    word_load = (phase_q == 2'd0) && word_valid;
    shreg_d   = shreg_q;
    out_d     = out_q;
    unique case (phase_q)
      2'd0: begin
        shreg_d = word_valid ? word : SYNC_WORD;
        out_d   = shreg_d[3:0];
      end
      2'd1:    out_d = shreg_q[7:4];
      2'd2:    out_d = shreg_q[11:8];
      default: out_d = shreg_q[15:12];
    endcase
  end

  always_ff @(posedge dtc_clk or negedge rst_n) begin
    if (!rst_n) begin
      phase_q <= 2'd0;
      shreg_q <= '0;
      out_q   <= '0;
    end else begin
      phase_q <= phase_d;
      shreg_q <= shreg_d;
      out_q   <= out_d;
    end
  end

  assign phase   = phase_q;
  assign dtc_out = out_q;

endmodule

// File: rtl/dtc_event_framer.sv
// Event-readout framer: walks enabled channels of the ADC sample buffer and feeds
// header, counter, channel blocks, XOR checksum and end flags to the lane serializer.
module dtc_event_framer
  import dtc_pkg::*;
#(
  parameter int unsigned N_CH      = 64,
  parameter int unsigned N_SAMPLES = 40,
  parameter int unsigned SAMPLE_W  = 12,
  parameter int unsigned CH_W      = (N_CH > 1) ? $clog2(N_CH) : 1,
  parameter int unsigned SA_W      = (N_SAMPLES > 1) ? $clog2(N_SAMPLES) : 1
) (
  input  logic                dtc_clk,
  input  logic                rst_n,
  input  logic                rdo_start,
  input  logic [7:0]          event_window,
  input  logic [N_CH-1:0]     ch_mask,
  output logic [CH_W-1:0]     adc_rd_ch,
  output logic [SA_W-1:0]     adc_rd_addr,
  input  logic [SAMPLE_W-1:0] adc_data,
  output logic [3:0]          dtc_out,
  output logic                busy,
  output logic                start_dropped,
  output logic [15:0]         event_cnt
);

  framer_state_t   state_q, state_d;
  logic [CH_W-1:0] rd_ch_q, rd_ch_d;
  logic [SA_W-1:0] rd_addr_q, rd_addr_d;
  logic [SA_W-1:0] last_q, last_d;
  logic [N_CH-1:0] mask_q, mask_d;
  logic [15:0]     event_cnt_q, event_cnt_d;
  logic [15:0]     frame_cnt_q, frame_cnt_d;
  logic [15:0]     csum_q, csum_d;
  logic [15:0]     sample_q, sample_d;
  logic            dropped_q, dropped_d;

  logic [15:0]     word;
  logic            word_valid;
  logic            word_load;
  logic [1:0]      phase;

  logic [SA_W-1:0] win_last;
  logic [CH_W-1:0] first_ch, next_ch;
  logic            has_first, has_next;

  // Window is stored as its last sample address; 0 or oversize means full depth.
  always_comb begin
    if (event_window == 8'd0 || {24'd0, event_window} > N_SAMPLES) begin
      win_last = SA_W'(N_SAMPLES - 1);
    end else begin
      win_last = SA_W'(event_window - 8'd1);
    end
  end

  // Downward scan so the lowest qualifying index wins.
  always_comb begin
    first_ch  = '0;
    next_ch   = '0;
    has_first = 1'b0;
    has_next  = 1'b0;
    for (int i = int'(N_CH) - 1; i >= 0; i--) begin
      if (mask_q[i]) begin
        first_ch  = CH_W'(i);
        has_first = 1'b1;
        if (CH_W'(i) > rd_ch_q) begin
          next_ch  = CH_W'(i);
          has_next = 1'b1;
        end
      end
    end
  end

  always_comb begin
    case (state_q)
      StHdr:          word = EVENT_HEADER;
      StEvCnt:        word = frame_cnt_q;
      StChHdr:        word = {CH_HDR_TAG, 12'(rd_ch_q)};
      StSample:       word = sample_q;
      StCsum:         word = csum_q;
      StEnd0, StEnd1: word = END_FLAG;
      default:        word = '0;
    endcase
  end

  assign word_valid = (state_q != StIdle);

  always_comb begin
    state_d     = state_q;
    rd_ch_d     = rd_ch_q;
    rd_addr_d   = rd_addr_q;
    last_d      = last_q;
    mask_d      = mask_q;
    event_cnt_d = event_cnt_q;
    frame_cnt_d = frame_cnt_q;
    csum_d      = csum_q;
    sample_d    = sample_q;
    dropped_d   = 1'b0;

    // Buffer address was set on the last load; data has settled by slot 2.
    if (state_q == StSample && phase == 2'd2) begin
      sample_d = 16'(adc_data);
    end

    if (state_q == StIdle) begin
      if (rdo_start) begin
        state_d     = StHdr;
        mask_d      = ch_mask;
        last_d      = win_last;
        frame_cnt_d = event_cnt_q;
        event_cnt_d = event_cnt_q + 16'd1;
        csum_d      = '0;
      end
    end else begin
      dropped_d = rdo_start;
      if (word_load) begin
        if (state_q inside {StHdr, StEvCnt, StChHdr, StSample}) begin
          csum_d = csum_q ^ word;
        end
        case (state_q)
          StHdr: state_d = StEvCnt;
          StEvCnt: begin
            if (has_first) begin
              state_d = StChHdr;
              rd_ch_d = first_ch;
            end else begin
              state_d = StCsum;
            end
          end
          StChHdr: begin
            state_d   = StSample;
            rd_addr_d = '0;
          end
          StSample: begin
            if (rd_addr_q == last_q) begin
              if (has_next) begin
                state_d = StChHdr;
                rd_ch_d = next_ch;
              end else begin
                state_d = StCsum;
              end
            end else begin
              rd_addr_d = rd_addr_q + 1'b1;
            end
          end
          StCsum:  state_d = StEnd0;
          StEnd0:  state_d = StEnd1;
          default: state_d = StIdle;
        endcase
      end
    end
  end

  always_ff @(posedge dtc_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      rd_ch_q     <= '0;
      rd_addr_q   <= '0;
      last_q      <= '0;
      mask_q      <= '0;
      event_cnt_q <= '0;
      frame_cnt_q <= '0;
      csum_q      <= '0;
      sample_q    <= '0;
      dropped_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      rd_ch_q     <= rd_ch_d;
      rd_addr_q   <= rd_addr_d;
      last_q      <= last_d;
      mask_q      <= mask_d;
      event_cnt_q <= event_cnt_d;
      frame_cnt_q <= frame_cnt_d;
      csum_q      <= csum_d;
      sample_q    <= sample_d;
      dropped_q   <= dropped_d;
    end
  end

  dtc_word_serializer u_serializer (
    .dtc_clk    (dtc_clk),
    .rst_n      (rst_n),
    .word       (word),
    .word_valid (word_valid),
    .word_load  (word_load),
    .phase      (phase),
    .dtc_out    (dtc_out)
  );

  assign adc_rd_ch     = rd_ch_q;
  assign adc_rd_addr   = rd_addr_q;
  assign busy          = (state_q != StIdle);
  assign start_dropped = dropped_q;
  assign event_cnt     = event_cnt_q;

endmodule

// File: tb/tb_dtc_event_framer.sv
// Randomized frame-level bench: reassembles lane nibbles into words and compares whole
// frames against a list-building reference model of the frame format.
module tb_dtc_event_framer;

  localparam int NCH = 4;
  localparam int NS  = 8;

  logic        dtc_clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        rdo_start = 1'b0;
  logic [7:0]  event_window = 8'd0;
  logic [3:0]  ch_mask = 4'd0;
  logic [1:0]  adc_rd_ch;
  logic [2:0]  adc_rd_addr;
  logic [11:0] adc_data = 12'd0;
  logic [3:0]  dtc_out;
  logic        busy;
  logic        start_dropped;
  logic [15:0] event_cnt;

  dtc_event_framer #(
    .N_CH      (NCH),
    .N_SAMPLES (NS),
    .SAMPLE_W  (12)
  ) dut (
    .dtc_clk       (dtc_clk),
    .rst_n         (rst_n),
    .rdo_start     (rdo_start),
    .event_window  (event_window),
    .ch_mask       (ch_mask),
    .adc_rd_ch     (adc_rd_ch),
    .adc_rd_addr   (adc_rd_addr),
    .adc_data      (adc_data),
    .dtc_out       (dtc_out),
    .busy          (busy),
    .start_dropped (start_dropped),
    .event_cnt     (event_cnt)
  );

  always #5 dtc_clk = ~dtc_clk;

  int          n_tests = 0;
  int          n_fail  = 0;
  logic [11:0] salt = 12'd0;
  logic [15:0] model_cnt = 16'd0;
  logic [15:0] got_q[$];
  logic [15:0] exp_q[$];
  int          nib_idx = 0;
  logic [15:0] wacc = 16'd0;
  int          drop_pulses = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [11:0] adc_fn(input int ch, input int a, input logic [11:0] s);
    return 12'(ch * 16 + a) ^ s;
  endfunction

  // Sample buffer with one register of read latency.
  always @(posedge dtc_clk) adc_data <= adc_fn(int'(adc_rd_ch), int'(adc_rd_addr), salt);

  always @(posedge dtc_clk) begin
    if (rst_n) begin
      #1;
      wacc[nib_idx*4 +: 4] = dtc_out;
      if (nib_idx == 3) begin
        got_q.push_back(wacc);
        nib_idx = 0;
      end else begin
        nib_idx++;
      end
    end
  end

  always @(negedge dtc_clk) if (rst_n && start_dropped) drop_pulses++;

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic build_model(input logic [3:0] mask, input logic [7:0] win_in);
    int w;
    logic [15:0] cs;
    w = (win_in == 8'd0 || int'(win_in) > NS) ? NS : int'(win_in);
    exp_q.delete();
    exp_q.push_back(16'h5C5C);
    exp_q.push_back(model_cnt);
    for (int ch = 0; ch < NCH; ch++) begin
      if (mask[ch]) begin
        exp_q.push_back(16'hA000 | 16'(ch));
        for (int a = 0; a < w; a++) exp_q.push_back({4'h0, adc_fn(ch, a, salt)});
      end
    end
    cs = 16'd0;
    foreach (exp_q[i]) cs ^= exp_q[i];
    exp_q.push_back(cs);
    exp_q.push_back(16'hC5D5);
    exp_q.push_back(16'hC5D5);
  endtask

  task automatic wait_idle(input string name);
    int waited = 0;
    while (busy && waited < 400) begin
      @(negedge dtc_clk);
      waited++;
    end
    check_eq({name, "_idle"}, busy, 0);
  endtask

  task automatic run_frame(input logic [3:0] mask, input logic [7:0] win_in, input int drop_at,
                           input string name);
    int waited, skip, len;
    build_model(mask, win_in);
    len = exp_q.size();
    wait_idle(name);
    @(negedge dtc_clk);
    ch_mask      = mask;
    event_window = win_in;
    rdo_start    = 1'b1;
    got_q.delete();
    drop_pulses  = 0;
    @(negedge dtc_clk);
    rdo_start = 1'b0;
    model_cnt = model_cnt + 16'd1;
    check_eq({name, "_busy_rise"}, busy, 1);
    check_eq({name, "_cnt_acc"}, event_cnt, model_cnt);
    if (drop_at > 0) begin
      repeat (drop_at) @(negedge dtc_clk);
      event_window = 8'd1;
      ch_mask      = ~mask;
      rdo_start    = 1'b1;
      @(negedge dtc_clk);
      rdo_start = 1'b0;
      @(negedge dtc_clk);
      check_eq({name, "_cnt_drop"}, event_cnt, model_cnt);
    end
    waited = 0;
    while (got_q.size() < len + 4 && waited < 4 * len + 80) begin
      @(negedge dtc_clk);
      waited++;
    end
    skip = 0;
    while (skip < got_q.size() && got_q[skip] == 16'hBC50) skip++;
    check_eq({name, "_hdr_lat"}, (skip <= 2), 1);
    for (int i = 0; i < len; i++) begin
      if (skip + i < got_q.size()) check_eq({name, "_word"}, got_q[skip+i], exp_q[i]);
      else check_eq({name, "_word_missing"}, 0, 1);
    end
    if (skip + len < got_q.size()) check_eq({name, "_tail_sync"}, got_q[skip+len], 16'hBC50);
    else check_eq({name, "_tail_missing"}, 0, 1);
    check_eq({name, "_busy_fall"}, busy, 0);
    check_eq({name, "_drop_pulses"}, drop_pulses, (drop_at > 0) ? 1 : 0);
    check_eq({name, "_cnt_end"}, event_cnt, model_cnt);
  endtask

  initial begin
    int waited;
    rst_n = 1'b0;
    repeat (3) @(negedge dtc_clk);
    check_eq("rst_dtc_out", dtc_out, 0);
    check_eq("rst_busy", busy, 0);
    check_eq("rst_dropped", start_dropped, 0);
    check_eq("rst_event_cnt", event_cnt, 0);
    check_eq("rst_rd_ch", adc_rd_ch, 0);
    check_eq("rst_rd_addr", adc_rd_addr, 0);
    rst_n   = 1'b1;
    nib_idx = 0;
    got_q.delete();
    waited = 0;
    while (got_q.size() < 2 && waited < 40) begin
      @(negedge dtc_clk);
      waited++;
    end
    check_eq("idle_sync", (got_q.size() > 0) ? got_q[0] : 16'h0, 16'hBC50);

    salt = 12'd0;
    run_frame(4'b0101, 8'd2, 0, "basic");
    run_frame(4'b0000, 8'd3, 0, "nomask");
    run_frame(4'b1001, 8'd0, 0, "clamp0");
    run_frame(4'b0110, 8'd200, 0, "clamp200");
    run_frame(4'b1111, 8'd3, 7, "drop");

    for (int k = 0; k < 6; k++) begin
      salt = 12'($urandom);
      run_frame(4'($urandom_range(0, 15)), 8'($urandom_range(0, 12)),
                (k % 2 == 1) ? int'($urandom_range(1, 12)) : 0, "rand");
    end

    wait_idle("wrap");
    @(negedge dtc_clk);
    force dut.event_cnt_q = 16'hFFFF;
    @(negedge dtc_clk);
    release dut.event_cnt_q;
    @(negedge dtc_clk);
    model_cnt = 16'hFFFF;
    check_eq("wrap_preload", event_cnt, 16'hFFFF);
    run_frame(4'b0010, 8'd1, 0, "wrap");
    check_eq("wrap_zero", event_cnt, 16'h0000);

    salt = 12'($urandom);
    wait_idle("abort");
    @(negedge dtc_clk);
    ch_mask      = 4'b1111;
    event_window = 8'd8;
    rdo_start    = 1'b1;
    @(negedge dtc_clk);
    rdo_start = 1'b0;
    repeat (40) @(negedge dtc_clk);
    @(posedge dtc_clk);
    #3;
    rst_n = 1'b0;
    #1;
    check_eq("abort_dtc_out", dtc_out, 0);
    check_eq("abort_busy", busy, 0);
    check_eq("abort_event_cnt", event_cnt, 0);
    repeat (2) @(negedge dtc_clk);
    rst_n     = 1'b1;
    nib_idx   = 0;
    model_cnt = 16'd0;
    got_q.delete();
    waited = 0;
    while (got_q.size() < 3 && waited < 60) begin
      @(negedge dtc_clk);
      waited++;
    end
    for (int i = 0; i < 3; i++) begin
      if (i < got_q.size()) check_eq("abort_sync", got_q[i], 16'hBC50);
      else check_eq("abort_sync_missing", 0, 1);
    end
    check_eq("abort_idle", busy, 0);
    run_frame(4'b0011, 8'd2, 0, "post_rst");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/dtc_event_framer.md
# dtc_event_framer

Parametrised event-readout framer and DTC lane serializer for the PHOS FEC DTC link. It produces the event frame after a readout command, pulled from the per-channel ADC sample buffer, and sends it as one nibble per clock. The frame is header, event counter, per-channel header and samples for unmasked channels only, XOR checksum and double end flag. It sits between the DTC command decoder (source of `rdo_start`) and the DDR output registers of the data/return lines. It replaces the fixed 64-channel, header-plus-ADC-only readout.

## Interface
- `N_CH`, 64: number of ADC channels, 1..256.
- `N_SAMPLES`, 40: maximum samples per channel, 1..256.
- `SAMPLE_W`, 12: ADC sample width, ≤16; zero-extended to 16 bits.
- `CH_W`, `$clog2(N_CH)` (min 1): channel index width.
- `SA_W`, `$clog2(N_SAMPLES)` (min 1): sample address width.
- `dtc_clk` in 1: link clock. One clock domain only.
- `rst_n` in 1: reset, asynchronous assert, active-low.
- `rdo_start` in 1: single-cycle readout request from the command decoder.
- `event_window` in 8: samples per channel, latched at frame start. A value of 0 or above N_SAMPLES clamps to N_SAMPLES.
- `ch_mask` in N_CH: 1 = channel enabled, latched at frame start.
- `adc_rd_ch` out CH_W: buffer channel address.
- `adc_rd_addr` out SA_W: buffer sample address.
- `adc_data` in SAMPLE_W: buffer read data. Valid ≤2 cycles after the address changes.
- `dtc_out` out 4: nibble to the DDR output stage.
- `busy` out 1: a frame is in progress.
- `start_dropped` out 1: one-cycle pulse when `rdo_start` arrives while busy.
- `event_cnt` out 16: number of frames accepted.

## Operation
- Constants: `EVENT_HEADER`=16'h5C5C, `SYNC_WORD`=16'hBC50, `END_FLAG`=16'hC5D5. A channel header is {4'hA, 12'(ch)}. A sample word is {zeros, adc_data}.
- Frame word order:
  - `EVENT_HEADER`
  - `event_cnt` value before increment
  - for each enabled channel, ascending index: channel header, then W samples at addresses 0..W-1
  - checksum, which is the XOR of every preceding word of the frame
  - `END_FLAG`, then `END_FLAG` again
- Frame length = 5 + Σenabled(1+W) words.
- Framer FSM states: IDLE, HDR, EVCNT, CH_HDR, SAMPLE, CSUM, END0, END1, then back to IDLE.
  - CH_HDR skips masked channels. If no channel is enabled, EVCNT goes straight to CSUM.
  - SAMPLE moves to the next enabled channel after address W-1.
  - The CH_HDR/SAMPLE sequence ends after the highest enabled channel.
- Serializer:
  - A free-running 2-bit phase counter runs from reset; phase 0 is the load slot.
  - At phase 0 it loads the framer word if one is valid (and the framer advances), otherwise it loads `SYNC_WORD`.
  - It outputs nibbles [3:0], [7:4], [11:8], [15:12] on consecutive cycles.
- ADC reads: the framer updates `adc_rd_ch`/`adc_rd_addr` only on load cycles. It captures `adc_data` at phase 2 into the next-word register.
- `rdo_start` in IDLE latches `event_window` (clamped) and `ch_mask`, and increments `event_cnt` (16'hFFFF wraps to 0).
- `rdo_start` while busy: the request is ignored, `start_dropped` pulses, and the frame in progress is unaffected.
- Reset values:
  - `dtc_out`=0, `busy`=0, `start_dropped`=0, `event_cnt`=0, addresses=0, phase=0, FSM=IDLE.
  - Reset during a frame aborts the frame; the first load after reset sends `SYNC_WORD`.

## Timing
- `rdo_start` at cycle t: `busy`=1 from t+1.
- `EVENT_HEADER` is loaded at the first phase-0 cycle at or after t+1. Its nibble [3:0] appears on `dtc_out` one cycle after the load.
- Each word occupies exactly 4 cycles. There are no bubbles inside a frame.
- `busy` falls in the cycle after the load of the second `END_FLAG`. `rdo_start` in that same cycle is accepted.
- Load latency: 1 cycle from load to first nibble. Required ADC read latency: ≤2 cycles.

## Structure
- Package `dtc_pkg`: header/sync/end constants, the channel-header tag 4'hA, and the framer state enum. Shared with the command decoder.
- Sub-module `dtc_word_serializer`: phase counter, word load, sync insertion and nibble mux. Its handshake is `word`/`word_valid`/`word_load`. The framer is the top-level logic.

## Test plan
- Basic frame: N_CH=4, N_SAMPLES=8, window=2, mask=4'b0101, adc_data=ch*16+addr.
  - Required words: 5C5C, 0000, A000, 0000, 0001, A002, 0020, 0021, 5C5E, C5D5, C5D5, then BC50 when idle.
- All channels masked: required words 5C5C, 0000, 5C5C, C5D5, C5D5 (checksum = 5C5C^0000).
- Window clamp: window=0 and then window=200 with N_SAMPLES=8 both give 8 samples per channel; the second frame carries counter 0001.
- `rdo_start` mid-frame: `start_dropped` pulses for one cycle, the frame is bit-identical to an undisturbed run, and `event_cnt` is unchanged.
- Reset wrap and abort:
  - Preload `event_cnt` to FFFF via 65535 frames (or force it): the next frame carries FFFF and `event_cnt` becomes 0000.
  - Assert `rst_n` low mid-SAMPLE: `dtc_out`=0 immediately; after release, BC50 words follow.
